// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit, one bit position per clock.
// A request (din, mode, amt) is taken on start while idle. The result is
// presented on dout/carry_out with a one-cycle done pulse and held there until
// the next done.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - request strobe, honoured only while idle
//   mode      - 0 none, 1 lsr, 2 lsl, 3 asr, 4 ror, 5 rol, 6/7 none
//   amt       - number of single-bit steps
//   din       - operand
//   busy      - high whenever not idle
//   done      - one-cycle result-valid pulse
//   dout      - result, held until the next done
//   carry_out - last bit shifted/rotated out, held with dout
module seq_shifter #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [2:0] MdLsr = 3'd1;
  localparam logic [2:0] MdLsl = 3'd2;
  localparam logic [2:0] MdAsr = 3'd3;
  localparam logic [2:0] MdRor = 3'd4;
  localparam logic [2:0] MdRol = 3'd5;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] shifted;
  logic             bit_out;
  logic             real_shift;

  // One-position step of the working register for the latched mode.
  always_comb begin
    shifted = sreg_q;
    bit_out = carry_q;
    case (mode_q)
      MdLsr: begin
        shifted = {1'b0, sreg_q[WIDTH-1:1]};
        bit_out = sreg_q[0];
      end
      MdLsl: begin
        shifted = {sreg_q[WIDTH-2:0], 1'b0};
        bit_out = sreg_q[WIDTH-1];
      end
      MdAsr: begin
        shifted = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
        bit_out = sreg_q[0];
      end
      MdRor: begin
        shifted = {sreg_q[0], sreg_q[WIDTH-1:1]};
        bit_out = sreg_q[0];
      end
      MdRol: begin
        shifted = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
        bit_out = sreg_q[WIDTH-1];
      end
      default: begin
        shifted = sreg_q;
        bit_out = carry_q;
      end
    endcase
  end

  // Requests with no real work skip SHIFT and go straight to DONE.
  assign real_shift = (amt != '0) && (mode >= MdLsr) && (mode <= MdRol);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          sreg_d  = din;
          cnt_d   = amt;
          mode_d  = mode;
          carry_d = 1'b0;
          if (real_shift) begin
            state_d = StShift;
          end else begin
            state_d = StDone;
            dout_d  = din;
            cout_d  = 1'b0;
          end
        end
      end
      StShift: begin
        sreg_d  = shifted;
        carry_d = bit_out;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          // Outputs are loaded on the edge that enters DONE.
          state_d = StDone;
          dout_d  = shifted;
          cout_d  = bit_out;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      carry_q <= 1'b0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign dout      = dout_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Testbench for seq_shifter: random and directed requests, a queue-based
// scoreboard filled by the stimulus and drained by a negedge monitor.
module tb_seq_shifter;

  localparam int W = 7;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   mode = '0;
  logic [A-1:0] amt = '0;
  logic [W-1:0] din = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] dout;
  logic         carry_out;

  seq_shifter #(.WIDTH(W), .AMT_W(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .amt       (amt),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .dout      (dout),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int cy;
    int start_cyc;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   hold_res = 0;
  int   hold_cy = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: whole-operation result from plain arithmetic on the operand.
  function automatic void ref_model(input int m, input int a, input int d,
                                    output int r, output int c, output int n);
    int mask;
    int sx;
    int k;
    mask = (1 << W) - 1;
    n = (a != 0 && m >= 1 && m <= 5) ? a : 0;
    r = d;
    c = 0;
    if (n != 0) begin
      case (m)
        1: begin
          r = d >> n;
          c = (n <= W) ? ((d >> (n - 1)) & 1) : 0;
        end
        2: begin
          r = (d << n) & mask;
          c = (n <= W) ? ((d >> (W - n)) & 1) : 0;
        end
        3: begin
          sx = ((d >> (W - 1)) & 1) != 0 ? (d | ~mask) : d;
          r = (sx >>> n) & mask;
          c = (sx >>> (n - 1)) & 1;
        end
        4: begin
          k = n % W;
          r = ((d >> k) | (d << (W - k))) & mask;
          c = (r >> (W - 1)) & 1;
        end
        default: begin
          k = n % W;
          r = ((d << k) | (d >> (W - k))) & mask;
          c = r & 1;
        end
      endcase
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_busy;
      bit exp_done;
      exp_busy = (sb.size() > 0) && (cyc > sb[0].start_cyc);
      exp_done = (sb.size() > 0) && (cyc == sb[0].done_cyc);
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
      if (exp_done) begin
        hold_res = sb[0].res;
        hold_cy  = sb[0].cy;
        void'(sb.pop_front());
      end
      chk("dout", int'(dout), hold_res);
      chk("carry_out", int'(carry_out), hold_cy);
    end
  end

  // Called at posedge+1; returns at posedge+1 once no request is outstanding.
  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0d expected idle within 200 cycles", busy);
      sb.delete();
    end
  endtask

  task automatic issue(input int m, input int a, input int d);
    exp_t e;
    int   r;
    int   c;
    int   n;
    wait_idle();
    ref_model(m, a, d, r, c, n);
    e.res       = r;
    e.cy        = c;
    e.start_cyc = cyc;
    e.done_cyc  = cyc + 1 + n;
    sb.push_back(e);
    start = 1'b1;
    mode  = 3'(m);
    amt   = A'(a);
    din   = W'(d);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    mon_en = 1'b1;
    cycles(1);

    // Directed cases from the functional description.
    issue(1, 3, 'b1011001);
    issue(2, 2, 'b1011001);
    issue(3, 2, 'b1011001);
    issue(5, 7, 'b1011001);
    issue(4, 1, 'b1011001);
    issue(1, 0, 'b0101010);
    issue(6, 5, 'b0101010);
    issue(7, 3, 'b1111111);
    issue(0, 7, 'b1000001);
    issue(3, 7, 'b1000000);
    issue(2, 7, 'b1010101);

    // Start pulsed mid-operation must be ignored.
    issue(1, 7, 'b1011001);
    start = 1'b1;
    mode  = 3'd2;
    amt   = 3'd1;
    din   = 7'b0110110;
    cycles(1);
    start = 1'b0;

    // Reset in the middle of an amt=6 operation discards it.
    issue(4, 6, 'b1101011);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    sb.delete();
    hold_res = 0;
    hold_cy  = 0;
    cycles(2);
    issue(5, 3, 'b1100101);

    // Reset and start together: reset wins, nothing accepted.
    wait_idle();
    rst   = 1'b1;
    start = 1'b1;
    mode  = 3'd1;
    amt   = 3'd2;
    din   = 7'b1111111;
    cycles(1);
    rst   = 1'b0;
    start = 1'b0;
    hold_res = 0;
    hold_cy  = 0;
    cycles(3);

    // Random requests, issued back-to-back as soon as the unit is idle.
    for (int i = 0; i < 60; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, (1 << W) - 1)));
    end
    wait_idle();
    cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
